// File: rtl/cpu6_mem_arb_pkg.sv
// Shared cpu6 memory-subsystem definitions: data width, default RAM size,
// port identifiers and the starvation-counter update rule.
`timescale 1ns/1ps

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

package cpu6_mem_arb_pkg;

  localparam int CPU6_MEM_AW = 13;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // A port's counter only grows while it keeps asking and keeps losing.
  function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                             input logic       req,
                                             input logic       gnt,
                                             input logic [3:0] lim);
    if (!req || gnt) return 4'd0;
    if (cnt >= lim) return lim;
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/cpu6_spram.sv
// Single-port word-organised RAM with per-byte write enables and a
// registered read port (data appears the cycle after the access).
`timescale 1ns/1ps

module cpu6_spram #(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 13
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [XLEN/8-1:0]   be,
  input  logic [MEM_AW-3:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  output logic [XLEN-1:0]     rdata
);

  localparam int DEPTH = 1 << (MEM_AW - 2);

  logic [XLEN-1:0] mem [DEPTH];

  // Contents are deliberately left uninitialised; reset never clears them.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < XLEN/8; k++) begin
          if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/cpu6_mem_arb.sv
// Arbitrates the cpu6 fetch and load/store ports onto one byte-writable RAM
// with bounded starvation and out-of-range error responses.
`timescale 1ns/1ps

module cpu6_mem_arb
  import cpu6_mem_arb_pkg::*;
#(
  parameter int XLEN       = `CPU6_XLEN,
  parameter int MEM_AW     = CPU6_MEM_AW,
  parameter bit DATA_PRIO  = 1'b1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [XLEN-1:0]    i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [XLEN-1:0]    i_rdata,
  output logic               i_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [XLEN/8-1:0]  d_be,
  input  logic [XLEN-1:0]    d_addr,
  input  logic [XLEN-1:0]    d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [XLEN-1:0]    d_rdata,
  output logic               d_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]      i_starve, d_starve;
  logic            i_in_range, d_in_range;
  port_e           acc_port;
  logic [XLEN-1:0] acc_addr;
  logic            acc_in_range;
  logic            ram_en, ram_we;
  logic [XLEN-1:0] ram_rdata;
  logic            d_store_q;
  logic [XLEN-1:0] i_hold, d_hold;
  logic            unused_addr_lsbs;

  assign i_in_range       = (i_addr[XLEN-1:MEM_AW] == '0);
  assign d_in_range       = (d_addr[XLEN-1:MEM_AW] == '0);
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // The tie winner is fixed by DATA_PRIO unless the loser has waited too long.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
        if (DATA_PRIO) begin
          if (i_starve == STARVE_LIM) i_gnt = 1'b1;
          else                        d_gnt = 1'b1;
        end else begin
          if (d_starve == STARVE_LIM) d_gnt = 1'b1;
          else                        i_gnt = 1'b1;
        end
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_starve <= 4'd0;
      d_starve <= 4'd0;
    end else begin
      i_starve <= starve_next(i_starve, i_req, i_gnt, STARVE_LIM);
      d_starve <= starve_next(d_starve, d_req, d_gnt, STARVE_LIM);
    end
  end

  // Grants are already suppressed during reset, so no RAM write can slip through.
  always_comb begin
    acc_port     = d_gnt ? PORT_D : PORT_I;
    acc_addr     = (acc_port == PORT_D) ? d_addr : i_addr;
    acc_in_range = (acc_port == PORT_D) ? d_in_range : i_in_range;
    ram_en       = (i_gnt || d_gnt) && acc_in_range;
    ram_we       = d_gnt && d_we && d_in_range;
  end

  cpu6_spram #(
    .XLEN   (XLEN),
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (d_be),
    .addr  (acc_addr[MEM_AW-1:2]),
    .wdata (d_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      i_rvalid  <= 1'b0;
      i_err     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_store_q <= 1'b0;
      i_hold    <= '0;
      d_hold    <= '0;
    end else begin
      i_rvalid  <= i_gnt;
      i_err     <= i_gnt && !i_in_range;
      d_rvalid  <= d_gnt;
      d_err     <= d_gnt && !d_in_range;
      d_store_q <= d_gnt && d_we;
      i_hold    <= i_rdata;
      d_hold    <= d_rdata;
    end
  end

  // The RAM's own read register supplies data; stores and errors read as zero.
  always_comb begin
    i_rdata = i_hold;
    if (i_rvalid) i_rdata = i_err ? '0 : ram_rdata;
    d_rdata = d_hold;
    if (d_rvalid) d_rdata = (d_err || d_store_q) ? '0 : ram_rdata;
  end

endmodule

// File: tb/tb_cpu6_mem_arb.sv
// Scoreboard bench for cpu6_mem_arb: a reference memory predicts each response
// at grant time, and the monitor checks it one cycle later.
`timescale 1ns/1ps

module tb_cpu6_mem_arb;
  import cpu6_mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [0:2047];
  resp_t       iq[$];
  resp_t       dq[$];
  resp_t       mon_r;
  int          mon_idx;
  logic        i_pend = 1'b0;
  logic        d_pend = 1'b0;
  bit          mon_en = 1'b0;
  int          w;

  always #5 clk = ~clk;

  cpu6_mem_arb dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic resp_t mkResp(input logic [31:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata;
    r.err   = err;
    return r;
  endfunction

  function automatic logic inRange(input logic [31:0] addr);
    return addr[31:13] == 19'd0;
  endfunction

  // Responses must come exactly one cycle after each grant; predictions are
  // taken from the reference memory at the moment of the grant.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("i_rvalid", {31'd0, i_rvalid}, {31'd0, i_pend});
      checkOutput("d_rvalid", {31'd0, d_rvalid}, {31'd0, d_pend});
      if (i_rvalid && iq.size() > 0) begin
        mon_r = iq.pop_front();
        checkOutput("i_rdata", i_rdata, mon_r.rdata);
        checkOutput("i_err", {31'd0, i_err}, {31'd0, mon_r.err});
      end
      if (d_rvalid && dq.size() > 0) begin
        mon_r = dq.pop_front();
        checkOutput("d_rdata", d_rdata, mon_r.rdata);
        checkOutput("d_err", {31'd0, d_err}, {31'd0, mon_r.err});
      end
      checkOutput("one_gnt", {31'd0, i_gnt & d_gnt}, 32'd0);

      i_pend = i_req & i_gnt;
      if (i_pend) begin
        mon_idx = int'(i_addr[12:2]);
        if (!inRange(i_addr)) iq.push_back(mkResp(32'd0, 1'b1));
        else                  iq.push_back(mkResp(model[mon_idx], 1'b0));
      end
      d_pend = d_req & d_gnt;
      if (d_pend) begin
        mon_idx = int'(d_addr[12:2]);
        if (!inRange(d_addr)) begin
          dq.push_back(mkResp(32'd0, 1'b1));
        end else if (d_we) begin
          for (int k = 0; k < 4; k++)
            if (d_be[k]) model[mon_idx][8*k +: 8] = d_wdata[8*k +: 8];
          dq.push_back(mkResp(32'd0, 1'b0));
        end else begin
          dq.push_back(mkResp(model[mon_idx], 1'b0));
        end
      end
    end
  end

  // Called at posedge+1; holds the request until granted and returns at
  // posedge+1 after the grant edge with req dropped, so calls chain back-to-back.
  task automatic applyStimulus(input port_e port, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int waits);
    bit got = 1'b0;
    waits = 0;
    if (port == PORT_D) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (!got && waits < 50) begin
      @(negedge clk);
      if ((port == PORT_D) ? d_gnt : i_gnt) got = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    if (!got) checkOutput("gnt_timeout", {31'd0, (port == PORT_D) ? d_gnt : i_gnt}, 32'd1);
    if (port == PORT_D) d_req = 1'b0;
    else                i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    checkOutput("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    checkOutput("rst_errs", {30'd0, i_err, d_err}, 32'd0);
    checkOutput("rst_i_rdata", i_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;

    $display("[TB] preload through the store port");
    applyStimulus(PORT_D, 1'b1, 4'hF, 32'h0000, 32'h0000_00A0, w);
    applyStimulus(PORT_D, 1'b1, 4'hF, 32'h0004, 32'h0000_00A1, w);
    applyStimulus(PORT_D, 1'b1, 4'hF, 32'h0008, 32'h0000_00A2, w);
    applyStimulus(PORT_D, 1'b1, 4'hF, 32'h0100, 32'h1122_3344, w);

    $display("[TB] back-to-back fetches");
    for (int a = 0; a < 3; a++) begin
      applyStimulus(PORT_I, 1'b0, 4'h0, 32'(4 * a), 32'd0, w);
      checkOutput("fetch_nowait", 32'(w), 32'd0);
    end
    @(negedge clk);
    checkOutput("fetch_last", i_rdata, 32'h0000_00A2);
    @(posedge clk); #1;

    $display("[TB] byte store then load");
    applyStimulus(PORT_D, 1'b1, 4'b0101, 32'h0100, 32'hAABB_CCDD, w);
    applyStimulus(PORT_D, 1'b0, 4'h0, 32'h0100, 32'd0, w);
    @(negedge clk);
    checkOutput("rmw_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("rmw_load", d_rdata, 32'h11BB_33DD);
    @(posedge clk); #1;

    $display("[TB] contention");
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("cont_i_gnt", {31'd0, i_gnt}, {31'd0, (c % 5) == 4});
      checkOutput("cont_d_gnt", {31'd0, d_gnt}, {31'd0, (c % 5) != 4});
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;

    $display("[TB] out-of-range accesses");
    applyStimulus(PORT_D, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, w);
    @(negedge clk);
    checkOutput("oor_d_err", {31'd0, d_err}, 32'd1);
    @(posedge clk); #1;
    applyStimulus(PORT_D, 1'b0, 4'h0, 32'h0000, 32'd0, w);
    @(negedge clk);
    checkOutput("no_alias", d_rdata, 32'h0000_00A0);
    @(posedge clk); #1;
    applyStimulus(PORT_I, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'd0, w);
    @(negedge clk);
    checkOutput("oor_i_err", {31'd0, i_err}, 32'd1);
    checkOutput("oor_i_rdata", i_rdata, 32'd0);
    @(posedge clk); #1;

    $display("[TB] reset mid-operation");
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("pre_rst_d_gnt", {31'd0, d_gnt}, 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h5555_5555;
    @(negedge clk);
    checkOutput("rst_gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    d_we = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("post_rst_valid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        checkOutput("post_rst_i_rdata", i_rdata, 32'd0);
        checkOutput("post_rst_d_rdata", d_rdata, 32'd0);
      end
      checkOutput("post_rst_i_gnt", {31'd0, i_gnt}, {31'd0, c == 4});
      checkOutput("post_rst_d_gnt", {31'd0, d_gnt}, {31'd0, c != 4});
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_blocked_write", i_rdata, 32'h0000_00A2);

    repeat (3) @(negedge clk);
    checkOutput("iq_drained", 32'(iq.size()), 32'd0);
    checkOutput("dq_drained", 32'(dq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu6_mem_arb.md
Name: cpu6_mem_arb

Overview:
- Parametrised memory subsystem for the cpu6 core.
- Arbitrates an instruction-fetch port and a load/store port onto one single-port, word-organised, byte-writable RAM.
- Uses explicit req/gnt/rvalid handshakes, so the core can be stalled.
- Adds bounded-starvation arbitration and out-of-range error reporting.
- Replaces the fixed dual-port RAM hookup at the top level.

Parameters:
- XLEN, 32, data/address width (= `CPU6_XLEN).
- MEM_AW, 13, log2 of RAM size in bytes; word index = addr[MEM_AW-1:2].
- DATA_PRIO, 1, 1 = data port wins ties; 0 = fetch port wins ties.
- STARVE_MAX, 4, consecutive lost arbitrations after which the losing port is forced to win (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  XLEN  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid (one cycle after i_gnt).
- i_rdata  out  XLEN  fetch data.
- i_err  out  1  fetch address out of range; qualified by i_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  XLEN/8  byte enables for stores.
- d_addr  in  XLEN  data byte address.
- d_wdata  in  XLEN  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data / store ack valid (one cycle after d_gnt).
- d_rdata  out  XLEN  load data; 0 for stores.
- d_err  out  1  data address out of range; qualified by d_rvalid.

Behaviour:
- Reset (synchronous, active-high): i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0; both starve counters = 0. RAM contents are not cleared.
- Grants are combinational from req and the registered starve state. At most one gnt per cycle. gnt = 0 while reset is high.
- Arbitration:
  - Single requester: it is granted.
  - Both requesting: the DATA_PRIO winner is granted.
  - Override: if the loser's starve counter == STARVE_MAX, the loser wins instead.
- Starve counters, one per port:
  - Increment when that port requests and is not granted.
  - Clear on that port's grant or when its req is low.
  - Saturate at STARVE_MAX.
- Requester rules:
  - Address, we, be and wdata must be stable while req is high and gnt is low.
  - Request is consumed on the req & gnt cycle.
  - Back-to-back requests are allowed; full throughput is 1 access per cycle.
- Range check: in range iff addr[XLEN-1:MEM_AW] == 0. addr[1:0] is ignored (word aligned).
- Grant of an out-of-range request:
  - No RAM access, no write.
  - Next cycle: rvalid = 1, err = 1, rdata = 0.
- Read latency: exactly 1 cycle. RAM read at the grant edge; rvalid/rdata/err registered, valid for exactly one cycle.
- Store: at the grant edge, bytes with d_be[k] = 1 are written; other bytes are unchanged. Next cycle d_rvalid = 1, d_rdata = 0, d_err = 0. d_be = 0 is a legal no-op write that still acks.
- Read-after-write: a load granted the cycle after a store to the same word returns the new data.
- i_rdata/d_rdata hold their last value while rvalid = 0 (not required by consumers).
- Reset while an access is granted: that access's rvalid is suppressed and any write in the reset cycle is blocked.

Decomposition:
- Shared package/defines (cpu6 defines file):
  - `CPU6_XLEN.
  - MEM_AW default.
  - Port-id constants PORT_I = 0, PORT_D = 1.
- Sub-module cpu6_spram: single-port synchronous RAM with byte-enable write and 1-cycle registered read, parametrised by XLEN and MEM_AW.
- Arbitration, starve counters and response registers stay in cpu6_mem_arb.

Test Plan:
- Fetch only: i_req = 1, i_addr = 0x0, 0x4, 0x8 consecutively with preloaded words 0xA0, 0xA1, 0xA2 -> i_gnt every cycle; i_rvalid one cycle later with matching data, no bubbles.
- Byte store then load:
  - Preload 0x11223344 at 0x100.
  - Store d_be = 4'b0101, d_wdata = 0xAABBCCDD -> d_rvalid ack next cycle.
  - Load 0x100 next cycle -> d_rdata = 0x11BB33DD.
- Contention, DATA_PRIO = 1: i_req and d_req held continuously, d_req re-issued every cycle -> d_gnt 4 cycles, then i_gnt forced on the 5th (STARVE_MAX = 4), then the pattern repeats.
- Out of range, MEM_AW = 13: d_we = 1, d_addr = 0x2000 -> d_rvalid = 1, d_err = 1; a subsequent load of 0x0000 shows no aliasing write.
- Fetch out of range: i_addr = 0xFFFF_FFFC -> i_rvalid = 1, i_err = 1, i_rdata = 0.
- Reset mid-operation: assert reset on the i_gnt cycle of a load -> no i_rvalid next cycle; all outputs 0; starve counters cleared; a store granted in the reset cycle leaves RAM unchanged.
